// File: rtl/fb_ctrl.sv
// fb_ctrl: frame-buffer controller; capture writes, optional frame clear (FB_CLEAR_EN), display read scan
module fb_ctrl #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 640*480,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cap_valid,
    output logic             o_cap_ready,
    input  logic             i_cap_sof,
    input  logic [WIDTH-1:0] i_cap_data,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_clear_value,
    output logic             o_clear_busy,
    output logic             o_clear_done,
    output logic             o_frame_done,
    input  logic             i_rd_req,
    input  logic             i_rd_sof,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_eof,
    output logic             o_bram_en,
    output logic             o_bram_wr,
    output logic [AW-1:0]    o_bram_wr_addr,
    output logic [WIDTH-1:0] o_bram_wdata,
    output logic             o_bram_rd,
    output logic [AW-1:0]    o_bram_rd_addr,
    input  logic [WIDTH-1:0] i_bram_rdata
);
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    state_t           state;
    logic [AW-1:0]    wr_ptr, rd_ptr, cap_addr, rd_addr;
    logic [WIDTH-1:0] clear_val;
    logic             clear_start;
`ifdef FB_CLEAR_EN
    assign clear_start  = i_clear;
    assign o_cap_ready  = (state == IDLE);
    assign o_clear_busy = (state == CLEAR);
`else
    logic unused_clear;
    assign unused_clear = i_clear;
    assign clear_start  = 1'b0;
    assign o_cap_ready  = 1'b1;
    assign o_clear_busy = 1'b0;
`endif
    assign o_rd_data = i_bram_rdata;
    // sof restarts either scan at address 0
    always_comb begin
        cap_addr = i_cap_sof ? '0 : wr_ptr;
        rd_addr  = i_rd_sof ? '0 : rd_ptr;
    end
    // write FSM: capture beats in IDLE, fill the whole frame in CLEAR; one registered write per cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            clear_val      <= '0;
            o_bram_en      <= 1'b0;
            o_bram_wr      <= 1'b0;
            o_bram_wr_addr <= '0;
            o_bram_wdata   <= '0;
            o_frame_done   <= 1'b0;
            o_clear_done   <= 1'b0;
        end else begin
            o_bram_en    <= 1'b0;
            o_bram_wr    <= 1'b0;
            o_frame_done <= 1'b0;
            o_clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cap_valid) begin
                        o_bram_en      <= 1'b1;
                        o_bram_wr      <= 1'b1;
                        o_bram_wr_addr <= cap_addr;
                        o_bram_wdata   <= i_cap_data;
                        wr_ptr         <= (cap_addr == LAST) ? '0 : cap_addr + 1'b1;
                        o_frame_done   <= (cap_addr == LAST);
                    end
                    if (clear_start) begin
                        state     <= CLEAR;
                        wr_ptr    <= '0;
                        clear_val <= i_clear_value;
                    end
                end
                CLEAR: begin
                    o_bram_en      <= 1'b1;
                    o_bram_wr      <= 1'b1;
                    o_bram_wr_addr <= wr_ptr;
                    o_bram_wdata   <= clear_val;
                    wr_ptr         <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                    if (wr_ptr == LAST) begin
                        o_clear_done <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // read scan: strobe the BRAM, then flag valid/eof when its data arrives a cycle later
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr         <= '0;
            o_bram_rd      <= 1'b0;
            o_bram_rd_addr <= '0;
            o_rd_valid     <= 1'b0;
            o_rd_eof       <= 1'b0;
        end else begin
            o_bram_rd  <= i_rd_req;
            o_rd_valid <= o_bram_rd;
            o_rd_eof   <= o_bram_rd && (o_bram_rd_addr == LAST);
            if (i_rd_req) begin
                o_bram_rd_addr <= rd_addr;
                rd_ptr         <= (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fb_ctrl.sv
// tb_fb_ctrl: directed checks of fb_ctrl with a small frame and a behavioural BRAM
module tb_fb_ctrl;
    localparam int W = 11;
    localparam int D = 16;
    localparam int AW = 4;
    logic          i_clk = 1'b0, i_rst = 1'b1;
    logic          i_cap_valid = 1'b0, i_cap_sof = 1'b0, i_clear = 1'b0;
    logic          i_rd_req = 1'b0, i_rd_sof = 1'b0;
    logic [W-1:0]  i_cap_data = '0, i_clear_value = '0, i_bram_rdata;
    logic          o_cap_ready, o_clear_busy, o_clear_done, o_frame_done;
    logic          o_rd_valid, o_rd_eof, o_bram_en, o_bram_wr, o_bram_rd;
    logic [W-1:0]  o_rd_data, o_bram_wdata, bram_q;
    logic [AW-1:0] o_bram_wr_addr, o_bram_rd_addr;
    logic [W-1:0]  mem [D];
    logic [W-1:0]  exp_mem [D];
    int            checks = 0, errors = 0;

    fb_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cap_valid(i_cap_valid), .o_cap_ready(o_cap_ready), .i_cap_sof(i_cap_sof), .i_cap_data(i_cap_data),
        .i_clear(i_clear), .i_clear_value(i_clear_value), .o_clear_busy(o_clear_busy), .o_clear_done(o_clear_done),
        .o_frame_done(o_frame_done),
        .i_rd_req(i_rd_req), .i_rd_sof(i_rd_sof), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_eof(o_rd_eof),
        .o_bram_en(o_bram_en), .o_bram_wr(o_bram_wr), .o_bram_wr_addr(o_bram_wr_addr), .o_bram_wdata(o_bram_wdata),
        .o_bram_rd(o_bram_rd), .o_bram_rd_addr(o_bram_rd_addr), .i_bram_rdata(i_bram_rdata)
    );

    always #5 i_clk = ~i_clk;

    // dual-port BRAM model: one-cycle read latency, read-before-write on collision
    always @(posedge i_clk) begin
        if (o_bram_en && o_bram_wr) mem[o_bram_wr_addr] <= o_bram_wdata;
        if (o_bram_rd) bram_q <= mem[o_bram_rd_addr];
    end
    assign i_bram_rdata = bram_q;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int addr, input int data);
        chk({tag, "_strobe"}, {o_bram_en, o_bram_wr}, 2'b11);
        chk({tag, "_addr"}, o_bram_wr_addr, addr);
        chk({tag, "_data"}, o_bram_wdata, data);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_ready", o_cap_ready, 1);
        chk("rst_wr", {o_bram_en, o_bram_wr}, 0);
        chk("rst_wr_addr", o_bram_wr_addr, 0);
        chk("rst_wdata", o_bram_wdata, 0);
        chk("rst_flags", {o_frame_done, o_clear_busy, o_clear_done}, 0);
        chk("rst_rd", {o_bram_rd, o_rd_valid, o_rd_eof}, 0);
        chk("rst_rd_addr", o_bram_rd_addr, 0);
        i_rst = 1'b0;

        // full frame, sof on first beat
        for (int n = 0; n < 16; n++) begin
            i_cap_valid = 1'b1;
            i_cap_sof = (n == 0);
            i_cap_data = W'(32'h100 + n);
            exp_mem[n] = W'(32'h100 + n);
            tick();
            chk_wr("cap", n, 32'h100 + n);
            chk("frame_done", o_frame_done, n == 15);
        end
        i_cap_valid = 1'b0;
        i_cap_sof = 1'b0;
        tick();
        chk("idle_wr", o_bram_wr, 0);
        chk("idle_frame_done", o_frame_done, 0);

        // mid-frame sof restarts at address 0
        for (int n = 0; n < 5; n++) begin
            i_cap_valid = 1'b1;
            i_cap_data = W'(32'h200 + n);
            exp_mem[n] = W'(32'h200 + n);
            tick();
            chk_wr("cap5", n, 32'h200 + n);
        end
        i_cap_sof = 1'b1;
        i_cap_data = 11'h2AA;
        exp_mem[0] = 11'h2AA;
        tick();
        chk_wr("sof", 0, 32'h2AA);
        i_cap_sof = 1'b0;
        i_cap_data = 11'h2BB;
        exp_mem[1] = 11'h2BB;
        tick();
        chk_wr("after_sof", 1, 32'h2BB);
        chk("after_sof_frame_done", o_frame_done, 0);

`ifdef FB_CLEAR_EN
        // clear while capturing: same-cycle beat lands at addr 2, then 16 fill writes
        i_cap_data = 11'h333;
        i_clear = 1'b1;
        i_clear_value = 11'h7FF;
        tick();
        chk_wr("clr_beat", 2, 32'h333);
        chk("clr_ready0", o_cap_ready, 0);
        chk("clr_busy", o_clear_busy, 1);
        i_clear = 1'b0;
        i_clear_value = 11'h000;
        i_cap_data = 11'h444;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_wr("clr", k, 32'h7FF);
            chk("clr_done", o_clear_done, k == 15);
            chk("clr_ready", o_cap_ready, k == 15);
            exp_mem[k] = 11'h7FF;
        end
        tick();
        chk_wr("post_clr", 0, 32'h444);
        chk("post_clr_busy", {o_clear_busy, o_clear_done}, 0);
        exp_mem[0] = 11'h444;
`else
        // clear is ignored: capture keeps flowing
        i_cap_data = 11'h333;
        i_clear = 1'b1;
        i_clear_value = 11'h7FF;
        exp_mem[2] = 11'h333;
        tick();
        chk_wr("noclr_beat", 2, 32'h333);
        chk("noclr_ready", o_cap_ready, 1);
        chk("noclr_busy", o_clear_busy, 0);
        i_clear = 1'b0;
        i_cap_data = 11'h444;
        exp_mem[3] = 11'h444;
        tick();
        chk_wr("noclr_next", 3, 32'h444);
        chk("noclr_flags", {o_clear_busy, o_clear_done, o_cap_ready}, 1);
`endif
        i_cap_valid = 1'b0;
        tick();

        // 17 back-to-back reads, sof first
        for (int j = 0; j < 18; j++) begin
            i_rd_req = (j < 17);
            i_rd_sof = (j == 0);
            tick();
            if (j < 17) begin
                chk("rd_strobe", o_bram_rd, 1);
                chk("rd_addr", o_bram_rd_addr, j % 16);
            end
            if (j >= 1) begin
                chk("rd_valid", o_rd_valid, 1);
                chk("rd_data", o_rd_data, exp_mem[(j - 1) % 16]);
                chk("rd_eof", o_rd_eof, j == 16);
            end else begin
                chk("rd_valid_lat", o_rd_valid, 0);
            end
        end
        i_rd_req = 1'b0;
        i_rd_sof = 1'b0;
        tick();
        chk("rd_idle", {o_bram_rd, o_rd_valid, o_rd_eof}, 0);

`ifdef FB_CLEAR_EN
        // reset in the middle of a clear
        i_clear = 1'b1;
        i_clear_value = 11'h055;
        tick();
        chk("rclr_busy", o_clear_busy, 1);
        chk("rclr_nowr", o_bram_wr, 0);
        i_clear = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_wr("rclr", k, 32'h055);
        end
        i_rst = 1'b1;
        tick();
        chk("rclr_rst_wr", o_bram_wr, 0);
        chk("rclr_rst_state", {o_cap_ready, o_clear_busy, o_clear_done}, 3'b100);
        i_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rclr_quiet", {o_bram_wr, o_clear_done, o_clear_busy}, 0);
        end
`else
        i_clear = 1'b1;
        tick();
        chk("noclr_pulse_wr", o_bram_wr, 0);
        chk("noclr_pulse_busy", {o_clear_busy, o_cap_ready}, 1);
        i_clear = 1'b0;
        tick();
        chk("noclr_pulse_done", o_clear_done, 0);
`endif

        // reset with a read in flight drops the valid
        i_rd_req = 1'b1;
        tick();
        chk("rrd_strobe", o_bram_rd, 1);
        i_rd_req = 1'b0;
        i_rst = 1'b1;
        tick();
        chk("rrd_dropped", {o_rd_valid, o_bram_rd}, 0);
        i_rst = 1'b0;
        tick();
        chk("rrd_still_low", o_rd_valid, 0);

        // pointers restart at 0 after reset
        i_cap_valid = 1'b1;
        i_cap_data = 11'h123;
        i_rd_req = 1'b1;
        tick();
        chk_wr("post_rst", 0, 32'h123);
        chk("post_rst_rd_addr", o_bram_rd_addr, 0);
        i_cap_valid = 1'b0;
        i_rd_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
